// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter (with barrel_shifter)
// Brief    : Two requesters share one combinational barrel shifter through a
//            round-robin grant and a single registered result slot.
// Revision : 1.0
// ============================================================================

module barrel_shifter #(
    parameter int bit_size = 8
) (
    input  logic [bit_size-1:0]         data,
    input  logic [$clog2(bit_size)-1:0] num_shift,
    input  logic                        direction,
    input  logic [1:0]                  sel,
    output logic [bit_size-1:0]         out,
    output logic                        overflow
);
    localparam int c_sw = $clog2(bit_size);

    logic [c_sw:0]         w_inv;
    logic [bit_size-1:0]   w_shl;
    logic [bit_size-1:0]   w_shr;
    logic [bit_size-1:0]   w_asr;
    logic [bit_size-1:0]   w_rol;
    logic [bit_size-1:0]   w_ror;
    logic [bit_size-1:0]   w_back_l;
    logic [bit_size-1:0]   w_back_a;

    assign w_inv = (c_sw+1)'(bit_size) - {1'b0, num_shift};
    assign w_shl = data << num_shift;
    assign w_shr = data >> num_shift;
    assign w_asr = $signed(data) >>> num_shift;
    assign w_rol = (data << num_shift) | (data >> w_inv);
    assign w_ror = (data >> num_shift) | (data << w_inv);

    // A left shift overflowed if shifting the result back does not restore the operand.
    assign w_back_l = w_shl >> num_shift;
    assign w_back_a = $signed(w_shl) >>> num_shift;

    always_comb begin
        out      = data;
        overflow = 1'b0;
        case (sel)
            2'd0: begin
                out      = direction ? w_shr : w_shl;
                overflow = !direction && (w_back_l != data);
            end
            2'd1: begin
                out      = direction ? w_asr : w_shl;
                overflow = !direction && (w_back_a != data);
            end
            2'd2: out = direction ? w_ror : w_rol;
            default: begin
                out      = data;
                overflow = 1'b0;
            end
        endcase
    end
endmodule

module shift_arbiter #(
    parameter int bit_size = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [bit_size-1:0]         req0_data,
    input  logic [$clog2(bit_size)-1:0] req0_num_shift,
    input  logic                        req0_direction,
    input  logic [1:0]                  req0_sel,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [bit_size-1:0]         req1_data,
    input  logic [$clog2(bit_size)-1:0] req1_num_shift,
    input  logic                        req1_direction,
    input  logic [1:0]                  req1_sel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [bit_size-1:0]         out_data,
    output logic                        out_overflow,
    output logic                        out_id,
    output logic                        out_err
);
    localparam int c_sw = $clog2(bit_size);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rr;
    logic                  w_grant;
    logic                  w_can_load;
    logic                  w_hs;
    logic [bit_size-1:0]   w_data;
    logic [c_sw-1:0]       w_num_shift;
    logic                  w_direction;
    logic [1:0]            w_sel;
    logic [bit_size-1:0]   w_sh_out;
    logic                  w_sh_ovf;

    // Idle cycles default to requester 0 so the shifter inputs never float.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) w_grant = r_rr;
        else if (req1_valid)          w_grant = 1'b1;
    end

    assign w_data      = w_grant ? req1_data      : req0_data;
    assign w_num_shift = w_grant ? req1_num_shift : req0_num_shift;
    assign w_direction = w_grant ? req1_direction : req0_direction;
    assign w_sel       = w_grant ? req1_sel       : req0_sel;

    barrel_shifter #(.bit_size(bit_size)) u_shifter (
        .data      (w_data),
        .num_shift (w_num_shift),
        .direction (w_direction),
        .sel       (w_sel),
        .out       (w_sh_out),
        .overflow  (w_sh_ovf)
    );

    assign out_valid  = (r_state == ST_FULL);
    assign w_can_load = !out_valid || out_ready;
    // Gating with rstn keeps both readies low for the whole reset window.
    assign req0_ready = rstn && !w_grant && req0_valid && w_can_load;
    assign req1_ready = rstn &&  w_grant && req1_valid && w_can_load;
    assign w_hs       = req0_ready || req1_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_hs) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_hs) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_EMPTY;
            r_rr         <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
            out_id       <= 1'b0;
            out_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                out_data     <= w_sh_out;
                out_overflow <= w_sh_ovf;
                out_id       <= w_grant;
                out_err      <= (w_sel == 2'd3);
                if (req0_valid && req1_valid) r_rr <= ~w_grant;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Brief    : Directed self-checking bench for shift_arbiter.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps

module tb_shift_arbiter;
    logic       clk = 1'b0;
    logic       rstn;
    logic       req0_valid, req0_ready, req0_direction;
    logic [7:0] req0_data;
    logic [2:0] req0_num_shift;
    logic [1:0] req0_sel;
    logic       req1_valid, req1_ready, req1_direction;
    logic [7:0] req1_data;
    logic [2:0] req1_num_shift;
    logic [1:0] req1_sel;
    logic       out_valid, out_ready, out_overflow, out_id, out_err;
    logic [7:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.bit_size(8)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_num_shift(req0_num_shift), .req0_direction(req0_direction), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_num_shift(req1_num_shift), .req1_direction(req1_direction), .req1_sel(req1_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_overflow(out_overflow), .out_id(out_id), .out_err(out_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [7:0] d, input logic [2:0] n,
                            input logic dir, input logic [1:0] s);
        req0_valid = v; req0_data = d; req0_num_shift = n; req0_direction = dir; req0_sel = s;
    endtask

    task automatic set_req1(input logic v, input logic [7:0] d, input logic [2:0] n,
                            input logic dir, input logic [1:0] s);
        req1_valid = v; req1_data = d; req1_num_shift = n; req1_direction = dir; req1_sel = s;
    endtask

    task automatic test_reset;
        rstn = 1'b0; out_ready = 1'b1;
        set_req0(1'b1, 8'h11, 3'd1, 1'b0, 2'd0);
        set_req1(1'b1, 8'h22, 3'd1, 1'b0, 2'd0);
        #2;
        n_cmp++;
        if ({out_valid, out_data, out_overflow, out_id, out_err} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h o=%b id=%b e=%b, want all 0",
                     out_valid, out_data, out_overflow, out_id, out_err);
        end
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ready: got %b%b, want 00", req0_ready, req1_ready);
        end
        tick;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold_valid: got %b, want 0", out_valid);
        end
        set_req0(1'b0, 8'h00, 3'd0, 1'b0, 2'd0);
        set_req1(1'b0, 8'h00, 3'd0, 1'b0, 2'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_single;
        set_req0(1'b1, 8'h0F, 3'd4, 1'b0, 2'd0);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got %b, want 1", req0_ready);
        end
        tick;
        req0_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_id, out_err, out_overflow} !== {1'b1, 8'hF0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_result: got v=%b d=%h id=%b e=%b o=%b, want v=1 d=f0 id=0 e=0 o=0",
                     out_valid, out_data, out_id, out_err, out_overflow);
        end
        tick;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_drain: got %b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        set_req1(1'b1, 8'h81, 3'd1, 1'b1, 2'd2);
        tick;
        set_req1(1'b1, 8'h80, 3'd3, 1'b1, 2'd1);
        n_cmp++;
        if ({out_valid, out_data, out_id} !== {1'b1, 8'hC0, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_first: got v=%b d=%h id=%b, want v=1 d=c0 id=1", out_valid, out_data, out_id);
        end
        tick;
        req1_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_id} !== {1'b1, 8'hF0, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_second: got v=%b d=%h id=%b, want v=1 d=f0 id=1", out_valid, out_data, out_id);
        end
        tick;
    endtask

    task automatic test_round_robin;
        rstn = 1'b0; #2; rstn = 1'b1;
        tick;
        set_req0(1'b1, 8'h01, 3'd1, 1'b0, 2'd0);
        set_req1(1'b1, 8'h10, 3'd1, 1'b1, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL rr_ready[%0d]: got %b%b, want %s", i, req0_ready, req1_ready,
                         (i % 2 == 0) ? "10" : "01");
            end
            tick;
            n_cmp++;
            if ({out_valid, out_id, out_data} !== ((i % 2 == 0) ? {1'b1, 1'b0, 8'h02} : {1'b1, 1'b1, 8'h08})) begin
                n_err++;
                $display("FAIL rr_result[%0d]: got v=%b id=%b d=%h", i, out_valid, out_id, out_data);
            end
        end
    endtask

    task automatic test_backpressure;
        // Held result is requester 1's 0x08 from the round-robin sequence.
        out_ready = 1'b0;
        set_req1(1'b0, 8'h00, 3'd0, 1'b0, 2'd0);
        set_req0(1'b1, 8'h03, 3'd2, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL bp_ready[%0d]: got %b%b, want 00", i, req0_ready, req1_ready);
            end
            tick;
            n_cmp++;
            if ({out_valid, out_data, out_id, out_err, out_overflow} !== {1'b1, 8'h08, 1'b1, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%b, want v=1 d=08 id=1", i, out_valid, out_data, out_id);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b, want 1", req0_ready);
        end
        tick;
        req0_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_id} !== {1'b1, 8'h0C, 1'b0}) begin
            n_err++;
            $display("FAIL bp_next: got v=%b d=%h id=%b, want v=1 d=0c id=0", out_valid, out_data, out_id);
        end
        tick;
    endtask

    task automatic test_ops;
        logic [7:0] d_in  [6] = '{8'hA5, 8'hC0, 8'h40, 8'h9A, 8'h9A, 8'h9A};
        logic [2:0] n_in  [6] = '{3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        logic [1:0] s_in  [6] = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
        logic       dir   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_d [6] = '{8'hA5, 8'h80, 8'h80, 8'h9A, 8'h9A, 8'h9A};
        logic       exp_o [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_e [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_req0(1'b1, d_in[i], n_in[i], dir[i], s_in[i]);
            tick;
            n_cmp++;
            if ({out_valid, out_data, out_overflow, out_err} !== {1'b1, exp_d[i], exp_o[i], exp_e[i]}) begin
                n_err++;
                $display("FAIL op[%0d]: got v=%b d=%h o=%b e=%b, want v=1 d=%h o=%b e=%b", i,
                         out_valid, out_data, out_overflow, out_err, exp_d[i], exp_o[i], exp_e[i]);
            end
        end
        req0_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        set_req1(1'b1, 8'h01, 3'd1, 1'b0, 2'd0);
        tick;
        req1_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_full: got %b, want 1", out_valid);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_id} !== {1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL rmid_async: got v=%b d=%h id=%b, want v=0 d=00 id=0", out_valid, out_data, out_id);
        end
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        set_req0(1'b1, 8'h05, 3'd1, 1'b0, 2'd0);
        set_req1(1'b1, 8'h06, 3'd1, 1'b0, 2'd0);
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL rmid_grant: got %b%b, want 10", req0_ready, req1_ready);
        end
        tick;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n_cmp++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 8'h0A}) begin
            n_err++;
            $display("FAIL rmid_result: got v=%b id=%b d=%h, want v=1 id=0 d=0a", out_valid, out_id, out_data);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_round_robin;
        test_backpressure;
        test_ops;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter bit_size, default 8, meaning the data width; it SHALL be a power of two and at least 4.
REQ-002 The port list SHALL be as follows, in this order (REQ-002 to REQ-016):
- clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 rstn, input, 1, reset; asynchronous, active-low.
REQ-004 req0_valid, input, 1, requester 0 has an operation pending.
REQ-005 req0_ready, output, 1, requester 0 operation accepted this cycle.
REQ-006 req0_data, input, bit_size, requester 0 operand.
REQ-007 req0_num_shift, input, $clog2(bit_size), requester 0 shift amount.
REQ-008 req0_direction, input, 1, requester 0 direction: 0 left, 1 right.
REQ-009 req0_sel, input, 2, requester 0 operation: 0 logical, 1 arithmetic, 2 rotate, 3 reserved.
REQ-010 Requester 1 SHALL have ports req1_valid, req1_ready, req1_data, req1_num_shift, req1_direction and req1_sel, identical to the requester 0 ports.
REQ-011 out_valid, output, 1, result register holds an undelivered result.
REQ-012 out_ready, input, 1, consumer accepts the result.
REQ-013 out_data, output, bit_size, shifted result.
REQ-014 out_overflow, output, 1, overflow flag from the shift operation.
REQ-015 out_id, output, 1, index of the requester that owns the result.
REQ-016 out_err, output, 1, result came from a reserved sel=3 request.

Function
REQ-017 The block SHALL instantiate exactly one combinational barrel_shifter (parameter bit_size; ports data, num_shift, direction, sel, out, overflow) and share it between both requesters.
REQ-018 Grant SHALL be computed combinationally:
- only one reqN_valid high: that requester wins;
- both high: the requester indicated by the round-robin priority pointer rr wins.
REQ-019 The barrel_shifter inputs SHALL be muxed from the winning requester; with no valid request they SHALL be driven from requester 0.
REQ-020 The block SHALL be able to accept a request when can_load = !out_valid || out_ready.
REQ-021 reqN_ready SHALL equal (grant==N) && reqN_valid && can_load; at most one ready SHALL be high per cycle.
REQ-022 Handshake on requester N is reqN_valid && reqN_ready. On that handshake the block SHALL, at the next edge:
- register out_data = shifter out;
- register out_overflow = shifter overflow;
- set out_id = N, out_valid = 1, out_err = (sel==3).
REQ-023 A sel=3 request SHALL be accepted normally; out_data SHALL be the unmodified operand and out_overflow SHALL be 0.
REQ-024 Latency SHALL be 1 cycle from request handshake to out_valid. Throughput SHALL be 1 result per cycle while out_ready stays high.
REQ-025 The output state machine SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1), with these transitions:
- EMPTY to FULL on a handshake;
- FULL to EMPTY on out_ready with no new handshake;
- FULL stays FULL on out_ready together with a handshake (old result delivered, new one loaded same edge);
- FULL holds all out_* stable while out_ready=0.
REQ-026 rr SHALL toggle to point at the non-granted requester only on a handshake where both valids were high. Otherwise rr SHALL remain unchanged.
REQ-027 A requester SHALL NOT be starved: with both valid continuously and out_ready=1, grants SHALL alternate 0,1,0,1.
REQ-028 num_shift=0 SHALL return the operand unchanged for every sel value.
REQ-029 Request fields not handshaked SHALL NOT affect any register.

Reset
REQ-030 While rstn=0 the block SHALL force out_valid=0, out_data=0, out_overflow=0, out_id=0, out_err=0 and rr=0 (requester 0 priority), immediately and without waiting for clk.
REQ-031 While rstn=0, req0_ready and req1_ready SHALL be 0.
REQ-032 Reset asserted while FULL SHALL discard the held result. After rstn rises, the first result SHALL be produced one cycle after the first handshake.

Verification
REQ-033 Scenario 1: req0 sends data=0x0F, shift=4, dir=0, sel=0, out_ready=1. Required response: next cycle out_valid=1, out_data=0xF0, out_id=0, out_err=0.
REQ-034 Scenario 2: req1 sends data=0x81, shift=1, dir=1, sel=2, then data=0x80, shift=3, dir=1, sel=1 on consecutive cycles. Required response: out_data=0xC0 then 0xF0 on consecutive cycles, out_id=1 both times.
REQ-035 Scenario 3: both requesters held valid for 4 handshakes after reset. Required response: grant order 0,1,0,1, never both ready in one cycle.
REQ-036 Scenario 4: out_ready=0 with a result held. Required response: out_* stable for 5 cycles and req0_ready=req1_ready=0. When out_ready=1 with a req0 pending, the old result is delivered and the new one appears the next cycle with no bubble.
REQ-037 Scenario 5: req0 sends sel=3, data=0xA5, shift=2. Required response: out_data=0xA5, out_err=1, out_overflow=0.
REQ-038 Scenario 6: rstn pulsed low mid-cycle while FULL. Required response: out_valid=0 before the next clk edge, rr=0, and the next simultaneous request is granted to req0.
